mc_control_fsm: RTL and testbench

- Multi-cycle MIPS main control unit; successor to the single-cycle opcode decoder.
- Sequences each instruction through FETCH/DECODE/execute/writeback states and drives datapath mux selects and enables per state.
- Waits on a memory-ready handshake, with a bounded timeout, and counts retired instructions.
- Sits between the instruction register (opcode/funct) and the shared-memory multi-cycle datapath.

---
 rtl/mc_control_fsm_if.sv | 38 +++
 rtl/mc_control_fsm.sv | 256 +++++++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multi-cycle control FSM and its datapath.
// master = control unit, slave = IR/ALU/memory side of the datapath.
interface mc_control_fsm_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       pc_write;
   logic       pc_write_cond;
   logic       pc_en;
   logic       iord;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic [1:0] reg_dst;
   logic [1:0] mem_to_reg;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic [1:0] pc_source;

   modport master (
      input  opcode, funct, zero, mem_ready,
      output pc_write, pc_write_cond, pc_en, iord,
      output mem_read, mem_write, ir_write,
      output reg_dst, mem_to_reg, reg_write,
      output alu_src_a, alu_src_b, alu_op, pc_source
   );

   modport slave (
      output opcode, funct, zero, mem_ready,
      input  pc_write, pc_write_cond, pc_en, iord,
      input  mem_read, mem_write, ir_write,
      input  reg_dst, mem_to_reg, reg_write,
      input  alu_src_a, alu_src_b, alu_op, pc_source
   );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main control FSM with memory-wait timeout and retire count.
// MC_CTRL_IMM_EN enables the addi/slti/andi/ori IMM_EXEC/IMM_WB path.
module mc_control_fsm #(
   parameter int WAIT_MAX = 15,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   mc_control_fsm_if.master bus,
   output logic [3:0]       state,
   output logic             illegal,
   output logic             fault,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [3:0] {
      S_RESET    = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEM_ADDR = 4'd3,
      S_MEM_RD   = 4'd4,
      S_MEM_WB   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_EXEC     = 4'd7,
      S_ALU_WB   = 4'd8,
      S_BRANCH   = 4'd9,
      S_JUMP     = 4'd10,
      S_JAL      = 4'd11,
      S_JR       = 4'd12,
      S_FAULT    = 4'd13,
      S_IMM_EXEC = 4'd14,
      S_IMM_WB   = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] FN_JR    = 6'b001000;
   localparam logic [7:0] WMAX     = 8'(WAIT_MAX);

   state_t     st;
   state_t     st_nx;
   logic [7:0] wcnt;
   logic       w_to;
   logic       in_wait;
   logic       retire;

   logic is_mem;
   logic is_rt;
   logic is_jr;
   logic is_beq;
   logic is_j;
   logic is_jal;
   logic is_imm;
   logic is_legal;

   assign is_mem = (bus.opcode == OP_LW) || (bus.opcode == OP_SW);
   assign is_rt  = (bus.opcode == OP_RTYPE) && (bus.funct != FN_JR);
   assign is_jr  = (bus.opcode == OP_RTYPE) && (bus.funct == FN_JR);
   assign is_beq = (bus.opcode == OP_BEQ);
   assign is_j   = (bus.opcode == OP_J);
   assign is_jal = (bus.opcode == OP_JAL);

`ifdef MC_CTRL_IMM_EN
   assign is_imm = (bus.opcode == 6'b001000) || (bus.opcode == 6'b001010)
                || (bus.opcode == 6'b001100) || (bus.opcode == 6'b001101);
`else
   assign is_imm = 1'b0;
`endif

   assign is_legal = is_mem | is_rt | is_jr | is_beq
                   | is_j | is_jal | is_imm;

   assign in_wait = (st == S_FETCH) || (st == S_MEM_RD)
                 || (st == S_MEM_WR);
   assign w_to    = (wcnt == WMAX);

   always_comb begin
      st_nx = st;
      unique case (st)
         S_RESET:    st_nx = S_FETCH;
         S_FETCH: begin
            if (bus.mem_ready)
               st_nx = S_DECODE;
            else if (w_to)
               st_nx = S_FAULT;
         end
         S_DECODE: begin
            unique case (1'b1)
               is_mem:  st_nx = S_MEM_ADDR;
               is_jr:   st_nx = S_JR;
               is_rt:   st_nx = S_EXEC;
               is_beq:  st_nx = S_BRANCH;
               is_j:    st_nx = S_JUMP;
               is_jal:  st_nx = S_JAL;
               is_imm:  st_nx = S_IMM_EXEC;
               default: st_nx = S_FETCH;
            endcase
         end
         // opcode bit 3 separates sw (101011) from lw (100011)
         S_MEM_ADDR: st_nx = bus.opcode[3] ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD: begin
            if (bus.mem_ready)
               st_nx = S_MEM_WB;
            else if (w_to)
               st_nx = S_FAULT;
         end
         S_MEM_WB:   st_nx = S_FETCH;
         S_MEM_WR: begin
            if (bus.mem_ready)
               st_nx = S_FETCH;
            else if (w_to)
               st_nx = S_FAULT;
         end
         S_EXEC:     st_nx = S_ALU_WB;
         S_ALU_WB:   st_nx = S_FETCH;
         S_BRANCH:   st_nx = S_FETCH;
         S_JUMP:     st_nx = S_FETCH;
         S_JAL:      st_nx = S_FETCH;
         S_JR:       st_nx = S_FETCH;
         S_FAULT:    st_nx = S_FAULT;
`ifdef MC_CTRL_IMM_EN
         S_IMM_EXEC: st_nx = S_IMM_WB;
         S_IMM_WB:   st_nx = S_FETCH;
`else
         S_IMM_EXEC: st_nx = S_FAULT;
         S_IMM_WB:   st_nx = S_FAULT;
`endif
      endcase
   end

   always_comb begin
      retire = 1'b0;
      if (st_nx == S_FETCH) begin
         unique case (st)
            S_MEM_WB, S_MEM_WR, S_ALU_WB, S_BRANCH,
            S_JUMP, S_JAL, S_JR, S_IMM_WB: retire = 1'b1;
            default:                       retire = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st      <= S_RESET;
         wcnt    <= 8'd0;
         retired <= '0;
      end else begin
         st <= st_nx;
         // any state change clears the count, so each wait starts fresh
         if (st_nx != st)
            wcnt <= 8'd0;
         else if (in_wait && !bus.mem_ready && !w_to)
            wcnt <= wcnt + 8'd1;
         if (retire)
            retired <= retired + CNT_W'(1);
      end
   end

   always_comb begin
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.iord          = 1'b0;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.ir_write      = 1'b0;
      bus.reg_dst       = 2'b00;
      bus.mem_to_reg    = 2'b00;
      bus.reg_write     = 1'b0;
      bus.alu_src_a     = 1'b0;
      bus.alu_src_b     = 2'b00;
      bus.alu_op        = 2'b00;
      bus.pc_source     = 2'b00;
      illegal           = 1'b0;
      fault             = 1'b0;
      unique case (st)
         S_FETCH: begin
            bus.mem_read  = 1'b1;
            bus.alu_src_b = 2'b01;
            bus.ir_write  = bus.mem_ready;
            bus.pc_write  = bus.mem_ready;
         end
         S_DECODE: begin
            bus.alu_src_b = 2'b11;
            illegal       = !is_legal;
         end
         S_MEM_ADDR: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'b10;
         end
         S_MEM_RD: begin
            bus.mem_read = 1'b1;
            bus.iord     = 1'b1;
         end
         S_MEM_WB: begin
            bus.mem_to_reg = 2'b01;
            bus.reg_write  = 1'b1;
         end
         S_MEM_WR: begin
            bus.mem_write = 1'b1;
            bus.iord      = 1'b1;
         end
         S_EXEC: begin
            bus.alu_src_a = 1'b1;
            bus.alu_op    = 2'b10;
         end
         S_ALU_WB: begin
            bus.reg_dst   = 2'b01;
            bus.reg_write = 1'b1;
         end
         S_BRANCH: begin
            bus.alu_src_a     = 1'b1;
            bus.alu_op        = 2'b01;
            bus.pc_write_cond = 1'b1;
            bus.pc_source     = 2'b01;
         end
         S_JUMP: begin
            bus.pc_write  = 1'b1;
            bus.pc_source = 2'b10;
         end
         S_JAL: begin
            bus.pc_write   = 1'b1;
            bus.pc_source  = 2'b10;
            bus.reg_dst    = 2'b10;
            bus.mem_to_reg = 2'b10;
            bus.reg_write  = 1'b1;
         end
         S_JR: begin
            bus.pc_write  = 1'b1;
            bus.pc_source = 2'b11;
         end
         S_FAULT:    fault = 1'b1;
`ifdef MC_CTRL_IMM_EN
         S_IMM_EXEC: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'b10;
            bus.alu_op    = 2'b11;
         end
         S_IMM_WB: begin
            bus.reg_dst    = 2'b00;
            bus.mem_to_reg = 2'b00;
            bus.reg_write  = 1'b1;
         end
`endif
         default: begin
         end
      endcase
   end

   assign bus.pc_en = bus.pc_write | (bus.pc_write_cond & bus.zero);
   assign state     = st;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized self-checking bench for mc_control_fsm.
// Instruction-level model expands each opcode into its expected state walk.
module tb_mc_control_fsm;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  state;
   logic        illegal;
   logic        fault;
   logic [31:0] retired;

   int          n_run = 0;
   int          n_fail = 0;
   int unsigned exp_ret = 0;

   mc_control_fsm_if bus ();

   mc_control_fsm #(
      .WAIT_MAX(15),
      .CNT_W(32)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus),
      .state(state),
      .illegal(illegal),
      .fault(fault),
      .retired(retired)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog");
   end

   typedef enum int {
      C_LW, C_SW, C_R, C_JR, C_BEQ, C_J, C_JAL, C_IMM, C_ILL
   } cls_t;

   function automatic cls_t classify(logic [5:0] op, logic [5:0] fn);
      case (op)
         6'b100011: return C_LW;
         6'b101011: return C_SW;
         6'b000000: return (fn == 6'b001000) ? C_JR : C_R;
         6'b000100: return C_BEQ;
         6'b000010: return C_J;
         6'b000011: return C_JAL;
`ifdef MC_CTRL_IMM_EN
         6'b001000, 6'b001010,
         6'b001100, 6'b001101: return C_IMM;
`endif
         default:   return C_ILL;
      endcase
   endfunction

   // control word: pw pwc pc_en iord mr mw irw rd m2r rw asa asb aop psrc ill flt
   function automatic logic [20:0] exp_word(int s, bit rdy, bit z, bit ill);
      logic pw, pwc, iord, mr, mw, irw, rw, asa, ilf, flt;
      logic [1:0] rd, m2r, asb, aop, psrc;
      {pw, pwc, iord, mr, mw, irw, rw, asa, ilf, flt} = '0;
      {rd, m2r, asb, aop, psrc} = '0;
      case (s)
         1:  begin mr = 1; asb = 2'd1; irw = rdy; pw = rdy; end
         2:  begin asb = 2'd3; ilf = ill; end
         3:  begin asa = 1; asb = 2'd2; end
         4:  begin mr = 1; iord = 1; end
         5:  begin m2r = 2'd1; rw = 1; end
         6:  begin mw = 1; iord = 1; end
         7:  begin asa = 1; aop = 2'd2; end
         8:  begin rd = 2'd1; rw = 1; end
         9:  begin asa = 1; aop = 2'd1; pwc = 1; psrc = 2'd1; end
         10: begin pw = 1; psrc = 2'd2; end
         11: begin pw = 1; psrc = 2'd2; rd = 2'd2; m2r = 2'd2; rw = 1; end
         12: begin pw = 1; psrc = 2'd3; end
         13: flt = 1;
         14: begin asa = 1; asb = 2'd2; aop = 2'd3; end
         15: rw = 1;
         default: ;
      endcase
      return {pw, pwc, pw | (pwc & z), iord, mr, mw, irw, rd, m2r, rw,
              asa, asb, aop, psrc, ilf, flt};
   endfunction

   function automatic logic [20:0] act_word();
      return {bus.pc_write, bus.pc_write_cond, bus.pc_en, bus.iord,
              bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_dst,
              bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
              bus.alu_op, bus.pc_source, illegal, fault};
   endfunction

   // one clock: drive mem_ready, check at negedge, advance past posedge
   task automatic step(int es, bit rdy, bit ill);
      logic [20:0] ew;
      bus.mem_ready = rdy;
      @(negedge clk);
      n_run++;
      if (state !== 4'(es)) begin
         n_fail++;
         $display("FAIL state: got %0d expected %0d", state, es);
      end
      ew = exp_word(es, rdy, bus.zero, ill);
      n_run++;
      if (act_word() !== ew) begin
         n_fail++;
         $display("FAIL ctrl(st %0d): got %h expected %h", es, act_word(), ew);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_retired(string tag);
      n_run++;
      if (retired !== exp_ret) begin
         n_fail++;
         $display("FAIL retired(%s): got %0d expected %0d", tag, retired, exp_ret);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      step(0, 1'($urandom), 0);
      rst_n = 1'b1;
      step(0, 1'($urandom), 0);
      exp_ret = 0;
      check_retired("reset");
   endtask

   // DUT is in FETCH on entry and back in FETCH on return
   task automatic run_instr(logic [5:0] op, logic [5:0] fn, bit z,
                            int fd, int md);
      cls_t c;
      bus.opcode = op;
      bus.funct  = fn;
      bus.zero   = z;
      c = classify(op, fn);
      for (int i = 0; i < fd; i++) step(1, 0, 0);
      step(1, 1, 0);
      step(2, 1'($urandom), c == C_ILL);
      case (c)
         C_LW: begin
            step(3, 1'($urandom), 0);
            for (int i = 0; i < md; i++) step(4, 0, 0);
            step(4, 1, 0);
            step(5, 1'($urandom), 0);
         end
         C_SW: begin
            step(3, 1'($urandom), 0);
            for (int i = 0; i < md; i++) step(6, 0, 0);
            step(6, 1, 0);
         end
         C_R:   begin step(7, 1'($urandom), 0); step(8, 1'($urandom), 0); end
         C_JR:  step(12, 1'($urandom), 0);
         C_BEQ: step(9, 1'($urandom), 0);
         C_J:   step(10, 1'($urandom), 0);
         C_JAL: step(11, 1'($urandom), 0);
         C_IMM: begin step(14, 1'($urandom), 0); step(15, 1'($urandom), 0); end
         default: ;
      endcase
      if (c != C_ILL) exp_ret++;
      check_retired("instr");
   endtask

   task automatic test_reset();
      bus.opcode = '0;
      bus.funct  = '0;
      bus.zero   = 1'b0;
      bus.mem_ready = 1'b0;
      do_reset();
   endtask

   task automatic test_lw();
      run_instr(6'b100011, 6'($urandom), 1'($urandom), 0, 0);
   endtask

   task automatic test_rtype_delay();
      run_instr(6'b000000, 6'b100000, 1'($urandom), 3, 0);
   endtask

   task automatic test_beq();
      run_instr(6'b000100, 6'($urandom), 1'b1, 0, 0);
      run_instr(6'b000100, 6'($urandom), 1'b0, 1, 0);
   endtask

   task automatic test_jal_jr();
      run_instr(6'b000011, 6'($urandom), 1'($urandom), 0, 0);
      run_instr(6'b000000, 6'b001000, 1'($urandom), 0, 0);
   endtask

   task automatic test_imm();
      run_instr(6'b001000, 6'($urandom), 1'($urandom), 0, 0);
      run_instr(6'b001101, 6'($urandom), 1'($urandom), 2, 0);
      run_instr(6'b111111, 6'($urandom), 1'($urandom), 0, 0);
   endtask

   task automatic test_wait_boundary();
      run_instr(6'b100011, 6'($urandom), 1'($urandom), 15, 15);
      run_instr(6'b101011, 6'($urandom), 1'($urandom), 0, 15);
   endtask

   task automatic test_random();
      logic [5:0] ops [8];
      logic [5:0] op;
      logic [5:0] fn;
      ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
              6'b000010, 6'b000011, 6'b001000, 6'b001100};
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 7) == 0) op = 6'($urandom);
         else op = ops[$urandom_range(0, 7)];
         fn = ($urandom_range(0, 2) == 0) ? 6'b001000 : 6'($urandom);
         run_instr(op, fn, 1'($urandom), $urandom_range(0, 3),
                   $urandom_range(0, 3));
      end
   endtask

   task automatic test_timeout();
      bus.opcode = 6'b100011;
      step(1, 1, 0);
      step(2, 0, 0);
      step(3, 0, 0);
      for (int i = 0; i < 16; i++) step(4, 0, 0);
      for (int i = 0; i < 4; i++) step(13, 1'($urandom), 0);
      do_reset();
      for (int i = 0; i < 16; i++) step(1, 0, 0);
      for (int i = 0; i < 3; i++) step(13, 1'($urandom), 0);
      do_reset();
   endtask

   task automatic test_abort();
      run_instr(6'b000000, 6'b100000, 1'b0, 0, 0);
      bus.opcode = 6'b101011;
      step(1, 1, 0);
      step(2, 0, 0);
      step(3, 0, 0);
      step(6, 0, 0);
      do_reset();
      run_instr(6'b100011, 6'($urandom), 1'b0, 1, 1);
   endtask

   initial begin
      test_reset();
      test_lw();
      do_reset();
      test_rtype_delay();
      do_reset();
      test_beq();
      test_jal_jr();
      test_imm();
      test_wait_boundary();
      test_random();
      test_timeout();
      test_abort();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
